// File: rtl/fp_max_reduce_pkg.sv
// Shared types and helpers for the streaming floating-point max reducer.
// Holds the FSM state encoding, status bit positions and the canonical-qNaN builder.
package fp_max_reduce_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int STATUS_NV = 4;
  localparam int STATUS_DZ = 3;
  localparam int STATUS_OF = 2;
  localparam int STATUS_UF = 1;
  localparam int STATUS_NX = 0;

  // Positive quiet NaN: exponent all ones, only the mantissa MSB set.
  function automatic logic [63:0] canon_qnan(input int expo_w, input int mant_w);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < expo_w; i++) v[mant_w+i] = 1'b1;
    v[mant_w-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fp_max_cmp.sv
// Combinational two-operand maximumNumber; operand a is the earlier element and wins ties.
// Zero latency, no flow control; reports a signalling-NaN contribution from either operand.
module fp_max_cmp
  import fp_max_reduce_pkg::*;
#(
  parameter int SIGN_W = 1,
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23,
  localparam int W = SIGN_W + EXPO_W + MANT_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res,
  output logic         a_wins,
  output logic         nv
);

  localparam logic [63:0] QNAN_FULL = canon_qnan(EXPO_W, MANT_W);
  localparam logic [W-1:0] QNAN = QNAN_FULL[W-1:0];

  logic              a_sign, b_sign;
  logic [EXPO_W-1:0] a_expo, b_expo;
  logic [MANT_W-1:0] a_mant, b_mant;
  logic [W-2:0]      a_mag, b_mag;
  logic              a_nan, b_nan, a_snan, b_snan;
  logic              b_gt;

  // Unpack and classify both operands.
  always_comb begin
    a_sign = a[W-1];
    b_sign = b[W-1];
    a_expo = a[MANT_W +: EXPO_W];
    b_expo = b[MANT_W +: EXPO_W];
    a_mant = a[MANT_W-1:0];
    b_mant = b[MANT_W-1:0];
    a_mag  = a[W-2:0];
    b_mag  = b[W-2:0];
    a_nan  = (&a_expo) && (|a_mant);
    b_nan  = (&b_expo) && (|b_mant);
    a_snan = a_nan && !a_mant[MANT_W-1];
    b_snan = b_nan && !b_mant[MANT_W-1];
  end

  // Strict b > a on the numeric order; +0 beats -0 through the sign rule.
  always_comb begin
    if (a_sign != b_sign) b_gt = !b_sign;
    else if (!a_sign)     b_gt = b_mag > a_mag;
    else                  b_gt = b_mag < a_mag;
  end

  always_comb begin
    res    = a;
    a_wins = 1'b1;
    if (a_nan && b_nan) begin
      res    = QNAN;
      a_wins = 1'b1;
    end else if (a_nan) begin
      res    = b;
      a_wins = 1'b0;
    end else if (b_nan) begin
      res    = a;
      a_wins = 1'b1;
    end else begin
      a_wins = !b_gt;
      res    = b_gt ? b : a;
    end
    nv = a_snan | b_snan;
  end

endmodule

// File: rtl/fp_max_reduce.sv
// Streaming IEEE-754 vector max; result valid the cycle after the in_last handshake.
// Holds the result until out_ready, with in_ready low meanwhile; FP_MAX_REDUCE_INDEX_EN adds out_idx.
module fp_max_reduce
  import fp_max_reduce_pkg::*;
#(
  parameter int SIGN_W = 1,
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23,
  parameter int IDX_W  = 16,
  localparam int W = SIGN_W + EXPO_W + MANT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [4:0]       out_status
`ifdef FP_MAX_REDUCE_INDEX_EN
  ,
  output logic [IDX_W-1:0] out_idx
`endif
);

  state_t         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic           nv_q, nv_d;
  logic [W-1:0]   cmp_a, cmp_res;
  logic           cmp_a_wins, cmp_nv;
  logic           accept;

  assign accept = in_valid && in_ready;
  // The first element is compared against itself so a lone NaN is canonicalised.
  assign cmp_a  = (state_q == IDLE) ? in_data : acc_q;

  fp_max_cmp #(
    .SIGN_W (SIGN_W),
    .EXPO_W (EXPO_W),
    .MANT_W (MANT_W)
  ) u_cmp (
    .a      (cmp_a),
    .b      (in_data),
    .res    (cmp_res),
    .a_wins (cmp_a_wins),
    .nv     (cmp_nv)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = in_last ? DONE : ACC;
      ACC:     if (accept && in_last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q != DONE);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    acc_d = acc_q;
    nv_d  = nv_q;
    if (accept) begin
      acc_d = cmp_res;
      nv_d  = ((state_q == IDLE) ? 1'b0 : nv_q) | cmp_nv;
    end else if (out_valid && out_ready) begin
      nv_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      nv_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      nv_q  <= nv_d;
    end
  end

  always_comb begin
    out_data              = acc_q;
    out_status            = '0;
    out_status[STATUS_NV] = nv_q;
  end

`ifdef FP_MAX_REDUCE_INDEX_EN
  localparam logic [IDX_W-1:0] IDX_ONE = 1;

  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (accept) begin
      if (state_q == IDLE) begin
        cnt_d = IDX_ONE;
        idx_d = '0;
      end else begin
        cnt_d = cnt_q + IDX_ONE;
        if (!cmp_a_wins) idx_d = cnt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign out_idx = idx_q;
`else
  logic [IDX_W-1:0] unused_idx;
  logic             unused_wins;
  assign unused_idx  = '0;
  assign unused_wins = cmp_a_wins;
`endif

endmodule
